// File: rtl/piece_bag_queue.sv
// piece_bag_queue: pulls whole 7-piece bags from the shuffler into a circular FIFO and exposes head and preview slots
module piece_bag_queue #(
  parameter int CAP = 16,
  parameter int PREVIEW = 3,
  localparam int CW = $clog2(CAP + 1),
  localparam int PW = $clog2(CAP)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  output logic                   perm_latch,
  output logic [2:0]             perm_idx,
  input  logic [2:0]             perm_val,
  input  logic                   pop,
  output logic [2:0]             piece,
  output logic                   piece_valid,
  output logic [3*PREVIEW-1:0]   preview,
  output logic [CW-1:0]          count,
  output logic [7:0]             bag_cnt,
  output logic                   bag_err
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK} state_t;
  state_t state;
  logic [2:0] k;
  logic [7:0] seen;
  logic [2:0] mem [CAP];
  logic [PW-1:0] head, tail;
  logic push_ok, pop_ok;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(CAP - 1) ? '0 : p + 1'b1;
  endfunction
  assign push_ok = state == S_FILL && count != CW'(CAP);
  assign pop_ok = pop && count != '0;
  assign perm_idx = k;
  assign piece_valid = count != '0;
  assign piece = piece_valid ? mem[head] : 3'd0;
  for (genvar i = 0; i < PREVIEW; i++) begin : g_pv
    assign preview[3*i +: 3] = count > CW'(i + 1) ? mem[PW'((32'(head) + i + 1) % CAP)] : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[tail] <= perm_val;
  end
  // seen[0] catches a zero from the shuffler, so a good bag is exactly 8'hFE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      state <= S_IDLE;
      k <= '0;
      seen <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      perm_latch <= 1'b0;
      bag_cnt <= '0;
      bag_err <= 1'b0;
    end else begin
      perm_latch <= 1'b0;
      if (push_ok) tail <= nxt(tail);
      if (pop_ok) head <= nxt(head);
      count <= count + CW'(push_ok) - CW'(pop_ok);
      case (state)
        S_IDLE: if (count <= CW'(CAP - 7)) begin
          state <= S_FILL;
          perm_latch <= 1'b1;
        end
        S_FILL: begin
          seen[perm_val] <= 1'b1;
          k <= k == 3'd6 ? 3'd0 : k + 3'd1;
          state <= k == 3'd6 ? S_CHECK : S_FILL;
        end
        S_CHECK: begin
          bag_err <= bag_err | (seen != 8'hFE);
          bag_cnt <= bag_cnt + 8'd1;
          seen <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piece_bag_queue.sv
// tb_piece_bag_queue: directed bring-up scenarios plus a random-pop run against a shuffler model and a piece-stream reference
module tb_piece_bag_queue;
  localparam int CAP = 16;
  localparam int PREVIEW = 3;
  logic clk = 0, rst = 0, clr = 0, pop = 0;
  logic perm_latch, piece_valid, bag_err;
  logic [2:0] perm_idx, perm_val, piece;
  logic [3*PREVIEW-1:0] preview;
  logic [4:0] count;
  logic [7:0] bag_cnt;
  int n_cmp = 0, n_bad = 0;
  int mode = 0, dup_cap = -1, n_cap = 0;
  logic [2:0] perm [7];
  int stream[$];

  always #5 clk = ~clk;

  piece_bag_queue #(.CAP(CAP), .PREVIEW(PREVIEW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .perm_latch(perm_latch), .perm_idx(perm_idx),
    .perm_val(perm_val), .pop(pop), .piece(piece), .piece_valid(piece_valid),
    .preview(preview), .count(count), .bag_cnt(bag_cnt), .bag_err(bag_err)
  );

  // shuffler model: captures a fresh permutation on the negedge while perm_latch is high
  assign perm_val = perm_idx < 3'd7 ? perm[perm_idx] : 3'd0;
  always @(negedge clk) begin
    if (perm_latch) begin
      int p[7];
      for (int i = 0; i < 7; i++) p[i] = i + 1;
      if (mode == 2) begin
        for (int i = 6; i > 0; i--) begin
          int j, t;
          j = $urandom_range(0, i);
          t = p[i]; p[i] = p[j]; p[j] = t;
        end
      end else if (n_cap == dup_cap) p[5] = 3;
      for (int i = 0; i < 7; i++) begin
        perm[i] = 3'(p[i]);
        stream.push_back(p[i]);
      end
      n_cap++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_latch(input int lim);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!perm_latch && c < lim);
    chk("latch_seen", perm_latch, 1);
  endtask

  task automatic check_fill();
    wait_latch(20);
    tick();
    chk("latch_one_cycle", perm_latch, 0);
    repeat (8) tick();
    chk("latch_second", perm_latch, 1);
    repeat (8) tick();
    chk("fill_count", count, 14);
    chk("fill_piece", piece, 1);
    chk("fill_preview", preview, {3'd4, 3'd3, 3'd2});
    chk("fill_bag_cnt", bag_cnt, 2);
    chk("fill_bag_err", bag_err, 0);
    chk("fill_no_latch", perm_latch, 0);
  endtask

  task automatic pulse_clr();
    clr = 1;
    tick();
    clr = 0;
  endtask

  initial begin
    int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 1};
    int base, npop, mask, cyc, c;
    logic [2:0] prev_piece;
    bit acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_latch", perm_latch, 0);
    chk("rst_valid", piece_valid, 0);
    chk("rst_bag_cnt", bag_cnt, 0);
    rst = 1;
    check_fill();

    pop = 1;
    for (int j = 0; j < 8; j++) begin
      chk("pop_seq", piece, exp_seq[j]);
      tick();
      if (j == 5) begin
        chk("refill_latch", perm_latch, 1);
        chk("refill_count", count, 8);
      end
    end
    pop = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      chk("cap_bound", int'(count <= CAP), 1);
    end
    chk("refill_done", count, 13);

    pulse_clr();
    dup_cap = n_cap;
    chk("clr_bag_cnt", bag_cnt, 0);
    c = 0;
    while (bag_cnt != 1 && c < 40) begin tick(); c++; end
    chk("dup_bag1", bag_cnt, 1);
    chk("dup_err", bag_err, 1);
    c = 0;
    while (bag_cnt != 2 && c < 40) begin tick(); c++; end
    chk("dup_bag2", bag_cnt, 2);
    chk("dup_err_sticky", bag_err, 1);

    pulse_clr();
    chk("clr_err", bag_err, 0);
    wait_latch(20);
    repeat (3) tick();
    chk("k3_idx", perm_idx, 3);
    chk("k3_count", count, 3);
    pulse_clr();
    chk("abort_count", count, 0);
    chk("abort_valid", piece_valid, 0);
    chk("abort_bag_cnt", bag_cnt, 0);
    chk("abort_latch", perm_latch, 0);
    tick();
    chk("restart_latch", perm_latch, 1);

    pop = 1;
    pulse_clr();
    chk("empty_count", count, 0);
    chk("empty_piece", piece, 0);
    chk("empty_preview", preview, 0);
    tick();
    chk("empty_pop_count", count, 0);
    chk("empty_pop_valid", piece_valid, 0);
    tick();
    chk("first_push_count", count, 1);
    chk("first_push_piece", piece, 1);
    tick();
    chk("push_pop_count", count, 1);
    chk("push_pop_piece", piece, 2);
    pop = 0;

    pulse_clr();
    wait_latch(20);
    repeat (2) tick();
    #2 rst = 0;
    #1;
    chk("async_count", count, 0);
    chk("async_latch", perm_latch, 0);
    chk("async_idx", perm_idx, 0);
    chk("async_piece", piece, 0);
    chk("async_valid", piece_valid, 0);
    chk("async_preview", preview, 0);
    chk("async_bag_cnt", bag_cnt, 0);
    @(posedge clk);
    #1 rst = 1;
    check_fill();

    mode = 2;
    pulse_clr();
    base = stream.size();
    npop = 0;
    mask = 0;
    cyc = 0;
    while (npop < 10000 && cyc < 60000) begin
      chk("rnd_valid", piece_valid, int'(count != 0));
      chk("rnd_cap", int'(count <= CAP), 1);
      if (piece_valid) begin
        if (base + npop < stream.size()) chk("rnd_piece", piece, stream[base + npop]);
        else chk("rnd_piece_unsourced", piece, 0);
      end
      for (int i = 0; i < PREVIEW; i++) begin
        int sl, ix;
        sl = preview[3*i +: 3];
        ix = base + npop + 1 + i;
        chk("rnd_pv_empty", int'(sl == 0), int'(count <= i + 1));
        if (sl != 0 && ix < stream.size()) chk("rnd_pv", sl, stream[ix]);
      end
      pop = $urandom_range(0, 3) != 0;
      acc = pop && piece_valid;
      prev_piece = piece;
      tick();
      cyc++;
      if (acc) begin
        mask |= 1 << prev_piece;
        npop++;
        if (npop % 7 == 0) begin
          chk("rnd_perm_group", mask, 8'hFE);
          mask = 0;
        end
      end
    end
    pop = 0;
    chk("rnd_pops", npop, 10000);
    chk("rnd_bag_err", bag_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
